// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver, the RX FIFO and its consumer.
// The FIFO sits on the slave side; the receiver/consumer side is the master.
interface uart_rx_fifo_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic [7:0]          RxData;
   logic                RxDone;
   logic                RdEn;
   logic                ClrOvf;
   logic [7:0]          DOut;
   logic                Empty;
   logic                Full;
   logic [DEPTH_LOG2:0] Count;
   logic                Overflow;

   modport master (
      output RxData, RxDone, RdEn, ClrOvf,
      input  DOut, Empty, Full, Count, Overflow
   );

   modport slave (
      input  RxData, RxDone, RdEn, ClrOvf,
      output DOut, Empty, Full, Count, Overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART RX byte buffer: RxDone edge synchroniser feeding a first-word-fall-through
// FIFO with sticky overflow flag. Reset is synchronous and active-high.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input logic           Clk,
   input logic           Rst_n,
   uart_rx_fifo_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CntFull = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic                  s1_q, s1_d;
   logic                  s2_q, s2_d;
   logic                  s3_q, s3_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [7:0]            mem_q [DEPTH];

   logic wr;
   logic empty;
   logic full;
   logic rd_en;
   logic wr_en;
   logic drop;

   always_comb begin
      s1_d     = bus.RxDone;
      s2_d     = s1_q;
      s3_d     = s2_q;
      wr       = s2_q & ~s3_q;
      empty    = (count_q == '0);
      full     = (count_q == CntFull);
      rd_en    = bus.RdEn & ~empty;
      // A pop at full frees the slot the incoming byte needs.
      wr_en    = wr & (~full | rd_en);
      drop     = wr & full & ~rd_en;
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (bus.ClrOvf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst_n) begin
         // Synchroniser parks high so RxDone held across reset is not an edge.
         s1_q     <= 1'b1;
         s2_q     <= 1'b1;
         s3_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         s3_q     <= s3_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (wr_en && !Rst_n) begin
         mem_q[wr_ptr_q] <= bus.RxData;
      end
   end

   assign bus.DOut     = empty ? 8'h00 : mem_q[rd_ptr_q];
   assign bus.Empty    = empty;
   assign bus.Full     = full;
   assign bus.Count    = count_q;
   assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: bytes are queued as the receiver side
// writes them and compared against DOut as the consumer pops.
module tb_uart_rx_fifo;
   localparam int DL2   = 4;
   localparam int DEPTH = 1 << DL2;

   logic clk;
   logic rst;
   int   vecs;
   int   errs;
   logic [7:0] exp_q [$];
   bit   ovf_m;

   uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

   uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
      .Clk   (clk),
      .Rst_n (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string nm);
      logic [7:0] ed;
      ed = (exp_q.size() == 0) ? 8'h00 : exp_q[0];
      vecs++;
      if (bus.Count !== 5'(exp_q.size())) begin
         errs++;
         $display("FAIL %s count: got %0d exp %0d", nm, bus.Count, exp_q.size());
      end
      vecs++;
      if (bus.Empty !== (exp_q.size() == 0)) begin
         errs++;
         $display("FAIL %s empty: got %b exp %b", nm, bus.Empty, exp_q.size() == 0);
      end
      vecs++;
      if (bus.Full !== (exp_q.size() == DEPTH)) begin
         errs++;
         $display("FAIL %s full: got %b exp %b", nm, bus.Full, exp_q.size() == DEPTH);
      end
      vecs++;
      if (bus.DOut !== ed) begin
         errs++;
         $display("FAIL %s dout: got %h exp %h", nm, bus.DOut, ed);
      end
      vecs++;
      if (bus.Overflow !== ovf_m) begin
         errs++;
         $display("FAIL %s overflow: got %b exp %b", nm, bus.Overflow, ovf_m);
      end
   endtask

   // One frame; optional RdEn / ClrOvf aligned with the internal write edge.
   task automatic send(input logic [7:0] b, input bit pop, input bit clr);
      bit full_m;
      logic [7:0] tmp;
      full_m = (exp_q.size() == DEPTH);
      bus.RxData = b;
      bus.RxDone = 1'b1;
      tick();
      tick();
      if (pop && exp_q.size() != 0) begin
         vecs++;
         if (bus.DOut !== exp_q[0]) begin
            errs++;
            $display("FAIL pop_at_wr: got %h exp %h", bus.DOut, exp_q[0]);
         end
         tmp = exp_q.pop_front();
      end
      bus.RdEn   = pop;
      bus.ClrOvf = clr;
      tick();
      bus.RdEn   = 1'b0;
      bus.ClrOvf = 1'b0;
      if (full_m && !pop) begin
         ovf_m = 1'b1;
      end else begin
         exp_q.push_back(b);
         if (clr) ovf_m = 1'b0;
      end
      check_state("send");
      bus.RxDone = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic pop_one();
      logic [7:0] tmp;
      if (exp_q.size() != 0) begin
         vecs++;
         if (bus.DOut !== exp_q[0]) begin
            errs++;
            $display("FAIL pop_data: got %h exp %h", bus.DOut, exp_q[0]);
         end
         tmp = exp_q.pop_front();
      end
      bus.RdEn = 1'b1;
      tick();
      bus.RdEn = 1'b0;
      check_state("pop");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
      ovf_m = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      bus.RxDone = 1'b1;
      bus.RxData = 8'h3C;
      rst = 1'b1;
      tick();
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
      ovf_m = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_state("reset");
      end
      bus.RxDone = 1'b0;
      tick();
      tick();
      tick();
      check_state("reset_lo");
   endtask

   task automatic test_single();
      bus.RxData = 8'hA5;
      bus.RxDone = 1'b1;
      tick();
      check_state("lat_k");
      tick();
      check_state("lat_k1");
      tick();
      exp_q.push_back(8'hA5);
      check_state("lat_k2");
      bus.RxDone = 1'b0;
      tick();
      tick();
      tick();
      pop_one();
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0, 1'b0);
      send(8'hFF, 1'b0, 1'b0);
      while (exp_q.size() != 0) pop_one();
      bus.ClrOvf = 1'b1;
      tick();
      bus.ClrOvf = 1'b0;
      ovf_m = 1'b0;
      check_state("drained");
   endtask

   task automatic test_full_wr_pop();
      do_reset();
      for (int i = 0; i < DEPTH; i++) send(8'h40 + 8'(i), 1'b0, 1'b0);
      send(8'hEE, 1'b1, 1'b0);
      while (exp_q.size() != 0) pop_one();
   endtask

   task automatic test_wrap();
      logic [7:0] r;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         r = 8'($urandom_range(0, 255));
         send(r, (i % 5 == 2), 1'b0);
         if (i % 3 == 0) send(r ^ 8'h5A, 1'b0, 1'b0);
         while (exp_q.size() != 0) pop_one();
         if (i % 4 == 0) pop_one();
      end
   endtask

   task automatic test_ovf_clear();
      do_reset();
      for (int i = 0; i < DEPTH; i++) send(8'h80 + 8'(i), 1'b0, 1'b0);
      send(8'h11, 1'b0, 1'b1);
      bus.ClrOvf = 1'b1;
      tick();
      bus.ClrOvf = 1'b0;
      ovf_m = 1'b0;
      check_state("clr_alone");
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(8'h21, 1'b0, 1'b0);
      send(8'h22, 1'b0, 1'b0);
      bus.RxData = 8'h23;
      bus.RxDone = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      ovf_m = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_state("rst_mid");
      end
      bus.RxDone = 1'b0;
      tick();
      tick();
      tick();
      send(8'h24, 1'b0, 1'b0);
      pop_one();
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      ovf_m = 1'b0;
      rst = 1'b1;
      bus.RxData = 8'h00;
      bus.RxDone = 1'b0;
      bus.RdEn   = 1'b0;
      bus.ClrOvf = 1'b0;
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_wr_pop();
      test_wrap();
      test_ovf_clear();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
